gpio_pin_unit: RTL and testbench
================================

// Module: gpio_pin_unit
// PURPOSE
//  Pin-side stage downstream of the special-function I/O registers. Drives pads
//  from the OUT/DIR register values. Synchronises and debounces raw pad inputs
//  into the read value loaded by the input register. Latches per-bit edge
//  interrupts with write-1-to-clear acknowledge.
// PARAMETERS
//  WIDTH            16  number of I/O bits (matches the 16-bit data bus)
//  SYNC_STAGES      2   flops in input synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  4   consecutive stable cycles required to accept a new level (>=1)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  RST       in   1      synchronous reset, active-high
//  out_val   in   WIDTH  value held by the output register
//  dir_val   in   WIDTH  value held by the direction register; 1=output, 0=input
//  pad_in    in   WIDTH  raw asynchronous pad levels
//  pad_out   out  WIDTH  registered pad drive value
//  pad_oe    out  WIDTH  registered pad output enable; 1=drive
//  rd_data   out  WIDTH  read value presented to the input register
//  rise_en   in   WIDTH  per-bit rising-edge interrupt enable
//  fall_en   in   WIDTH  per-bit falling-edge interrupt enable
//  irq_ack   in   WIDTH  per-bit write-1-to-clear for irq_pend; one-cycle pulse
//  irq_pend  out  WIDTH  latched pending interrupt bits
//  irq       out  1      OR of irq_pend, no extra latency
// BEHAVIOUR
//  Reset: every flop clears on a clk edge with RST=1, including sync chain, debounce
//   counters, stable values, pad_out, pad_oe, and irq_pend. Outputs therefore read
//   0 the cycle after reset, so all pins are inputs. RST overrides all other inputs.
//  Drive: pad_out<=out_val, pad_oe<=dir_val each cycle; 1-cycle latency.
//  Sync: pad_in enters a SYNC_STAGES-deep per-bit chain; s = last stage.
//  Debounce, per bit, independent counter cnt (width clog2(DEBOUNCE_CYCLES)+1):
//   - s==stable: cnt<=0.
//   - s!=stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0 (accept event).
//   - A glitch shorter than DEBOUNCE_CYCLES resets cnt and never reaches stable.
//   - Pad step to stable change latency is exactly SYNC_STAGES+DEBOUNCE_CYCLES edges.
//  rd_data[i] = dir_val[i] ? pad_out[i] : stable[i]. This is combinational from
//   registers, so output bits read back the driven value.
//  Interrupts, per bit, evaluated on the accept event only:
//   - set = accept & ~dir_val[i] & ((s==1 & rise_en[i]) | (s==0 & fall_en[i])).
//   - irq_pend[i] <= set ? 1 : (irq_ack[i] ? 0 : irq_pend[i]).
//   - Simultaneous set and ack: set wins, so pending stays 1 and no edge is lost.
//   - Ack on a clear bit has no effect. Enables do not clear already-pending bits.
//   - Output-direction bits keep debouncing but never set pending.
//  Direction change 1->0: stable is not reinitialised. The first accepted
//   difference after the change may raise an edge interrupt.
//  Reset mid-debounce: counter and stable clear. The level must then be re-qualified
//   for the full SYNC_STAGES+DEBOUNCE_CYCLES.
// TESTING (defaults WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 RST=1 one cycle, pad_in=16'hFFFF -> next cycle pad_oe=0, pad_out=0,
//    irq_pend=0, irq=0, rd_data=0.
//  2 dir_val=16'h00FF, out_val=16'hA5A5 -> 1 cycle later pad_oe=16'h00FF,
//    pad_out=16'hA5A5, rd_data[7:0]=8'hA5.
//  3 dir=0, pad_in[3] high for 3 cycles then low -> rd_data[3] stays 0 and no irq.
//    Held high -> rd_data[3]=1 exactly 6 edges after the step.
//  4 rise_en[3]=1, bit 3 rises -> irq_pend[3]=1 and irq=1 on the accept edge.
//    irq_ack=16'h0008 for 1 cycle -> irq_pend[3]=0 and irq=0 next cycle.
//  5 fall_en[5]=1, irq_ack[5] asserted on the same edge bit 5's fall is accepted
//    -> irq_pend[5] remains 1.
//  6 pad_in[0] steps high, RST pulsed 3 edges later -> rd_data[0]=0. It becomes 1
//    only 6 edges after RST deasserts.

Source files
------------

// File: rtl/gpio_pin_unit_if.sv
// Pin-side bundle between the GPIO register block and the pin unit.
// master = register block / bench side, slave = gpio_pin_unit.
interface gpio_pin_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_val;
    logic [WIDTH-1:0] dir_val;
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] pad_out;
    logic [WIDTH-1:0] pad_oe;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_ack;
    logic [WIDTH-1:0] irq_pend;
    logic             irq;

    modport master (
        output out_val, dir_val, pad_in, rise_en, fall_en, irq_ack,
        input  pad_out, pad_oe, rd_data, irq_pend, irq
    );

    modport slave (
        input  out_val, dir_val, pad_in, rise_en, fall_en, irq_ack,
        output pad_out, pad_oe, rd_data, irq_pend, irq
    );
endinterface

// File: rtl/gpio_pin_unit.sv
// GPIO pin stage: registered pad drive, input synchroniser + per-bit debounce,
// and latched edge interrupts with write-1-to-clear acknowledge.
module gpio_pin_unit #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic           clk,
    input logic           RST,
    gpio_pin_unit_if.slave bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pad_out_q;
    logic [WIDTH-1:0] pad_oe_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] irq_pend_q;

    // Pad drive
    always_ff @(posedge clk) begin
        if (RST) begin
            pad_out_q <= '0;
            pad_oe_q  <= '0;
        end else begin
            pad_out_q <= bus.out_val;
            pad_oe_q  <= bus.dir_val;
        end
    end

    // Synchroniser chain; s is the last stage
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A new level is accepted once it has differed from stable for DEBOUNCE_CYCLES samples
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == stable_q[i] || cnt_q[i] == CNT_MAX) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            stable_q <= '0;
        end else begin
            stable_q <= (stable_q & ~accept) | (s & accept);
        end
    end

    // Edge interrupts only fire on input-direction bits; a new set beats a same-cycle ack
    assign set = accept & ~bus.dir_val & ((s & bus.rise_en) | (~s & bus.fall_en));

    always_ff @(posedge clk) begin
        if (RST) begin
            irq_pend_q <= '0;
        end else begin
            irq_pend_q <= set | (irq_pend_q & ~bus.irq_ack);
        end
    end

    assign bus.pad_out  = pad_out_q;
    assign bus.pad_oe   = pad_oe_q;
    assign bus.rd_data  = (bus.dir_val & pad_out_q) | (~bus.dir_val & stable_q);
    assign bus.irq_pend = irq_pend_q;
    assign bus.irq      = |irq_pend_q;
endmodule

// File: tb/tb_gpio_pin_unit.sv
// Self-checking bench for gpio_pin_unit: expectations are queued with the
// stimulus for each clock and compared against the DUT after that edge.
module tb_gpio_pin_unit;
    localparam int W = 16;

    localparam int SEL_PAD_OUT = 0;
    localparam int SEL_PAD_OE  = 1;
    localparam int SEL_RD      = 2;
    localparam int SEL_PEND    = 3;
    localparam int SEL_IRQ     = 4;

    logic clk;
    logic RST;

    gpio_pin_unit_if #(.WIDTH(W)) bus ();

    gpio_pin_unit #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] observe(input int sel);
        case (sel)
            SEL_PAD_OUT: observe = bus.pad_out;
            SEL_PAD_OE:  observe = bus.pad_oe;
            SEL_RD:      observe = bus.rd_data;
            SEL_PEND:    observe = bus.irq_pend;
            default:     observe = {{(W-1){1'b0}}, bus.irq};
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic [W-1:0] val);
        exp_q.push_back(val);
        sel_q.push_back(sel);
        tag_q.push_back(tag);
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge
    task automatic step();
        logic [W-1:0] e;
        int           sl;
        string        t;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            sl = sel_q.pop_front();
            t  = tag_q.pop_front();
            check_val(t, observe(sl), e);
        end
    endtask

    // Driver
    task automatic drive(input logic [W-1:0] pin, input logic [W-1:0] outv, input logic [W-1:0] dirv);
        bus.pad_in  = pin;
        bus.out_val = outv;
        bus.dir_val = dirv;
    endtask

    initial begin
        logic [W-1:0] r_out, r_dir;

        // Reset with everything else asserted
        RST         = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 16'hFFFF);
        bus.rise_en = '0;
        bus.fall_en = '0;
        bus.irq_ack = '0;
        expect_out(SEL_PAD_OE,  "rst_oe",   16'h0000);
        expect_out(SEL_PAD_OUT, "rst_out",  16'h0000);
        expect_out(SEL_PEND,    "rst_pend", 16'h0000);
        expect_out(SEL_IRQ,     "rst_irq",  16'h0000);
        expect_out(SEL_RD,      "rst_rd",   16'h0000);
        step();

        RST = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000);
        for (int c = 0; c < 8; c++) step();
        expect_out(SEL_RD, "idle_rd", 16'h0000);
        step();

        // Pad drive and read-back of output bits
        drive(16'h0000, 16'hA5A5, 16'h00FF);
        expect_out(SEL_PAD_OE,  "drv_oe",  16'h00FF);
        expect_out(SEL_PAD_OUT, "drv_out", 16'hA5A5);
        expect_out(SEL_RD,      "drv_rd",  16'h00A5);
        step();
        drive(16'h0000, 16'h0000, 16'h0000);
        expect_out(SEL_PAD_OE, "drv_oe_off", 16'h0000);
        expect_out(SEL_RD,     "drv_rd_off", 16'h0000);
        step();

        // Glitch of 3 cycles on bit 3 is filtered
        bus.rise_en = 16'h0008;
        for (int c = 0; c < 10; c++) begin
            bus.pad_in = (c < 3) ? 16'h0008 : 16'h0000;
            expect_out(SEL_RD,  "glitch_rd",  16'h0000);
            expect_out(SEL_IRQ, "glitch_irq", 16'h0000);
            step();
        end

        // Held step on bit 3: accepted exactly on the 6th edge with rising irq
        bus.pad_in = 16'h0008;
        for (int c = 1; c <= 6; c++) begin
            expect_out(SEL_RD,   "rise_rd",   (c == 6) ? 16'h0008 : 16'h0000);
            expect_out(SEL_PEND, "rise_pend", (c == 6) ? 16'h0008 : 16'h0000);
            step();
        end
        expect_out(SEL_PEND, "rise_hold", 16'h0008);
        expect_out(SEL_IRQ,  "rise_irq",  16'h0001);
        step();

        // Acknowledge, then acknowledge an already-clear bit
        bus.irq_ack = 16'h0008;
        expect_out(SEL_PEND, "ack_pend", 16'h0000);
        expect_out(SEL_IRQ,  "ack_irq",  16'h0000);
        step();
        bus.irq_ack = 16'h0000;
        expect_out(SEL_PEND, "ack_after", 16'h0000);
        step();
        bus.irq_ack = 16'h0008;
        expect_out(SEL_PEND, "ack_clear_bit", 16'h0000);
        step();
        bus.irq_ack = 16'h0000;

        // Bit 5 rises with only fall enabled: no pending
        bus.rise_en = 16'h0000;
        bus.fall_en = 16'h0020;
        bus.pad_in  = 16'h0028;
        for (int c = 1; c <= 8; c++) step();
        expect_out(SEL_RD,   "b5_high_rd",   16'h0028);
        expect_out(SEL_PEND, "b5_high_pend", 16'h0000);
        step();

        // Bit 5 fall accepted on the same edge as its ack: set wins
        bus.pad_in = 16'h0008;
        for (int c = 1; c <= 6; c++) begin
            bus.irq_ack = (c == 6) ? 16'h0020 : 16'h0000;
            expect_out(SEL_PEND, "fall_ack_pend", (c == 6) ? 16'h0020 : 16'h0000);
            step();
        end
        bus.irq_ack = 16'h0000;
        expect_out(SEL_PEND, "fall_kept", 16'h0020);
        expect_out(SEL_IRQ,  "fall_irq",  16'h0001);
        step();
        bus.fall_en = 16'h0000;
        expect_out(SEL_PEND, "en_off_keeps", 16'h0020);
        step();
        bus.irq_ack = 16'h0020;
        expect_out(SEL_PEND, "fall_ack", 16'h0000);
        step();
        bus.irq_ack = 16'h0000;

        // Output-direction bit 7 debounces but never sets pending
        bus.rise_en = 16'h0080;
        drive(16'h0088, 16'h0000, 16'h0080);
        for (int c = 1; c <= 8; c++) begin
            expect_out(SEL_PEND, "outdir_pend", 16'h0000);
            step();
        end
        expect_out(SEL_RD, "outdir_rd", 16'h0008);
        step();
        // Switch to input: stable already tracked the high level
        drive(16'h0088, 16'h0000, 16'h0000);
        expect_out(SEL_RD,   "dir_sw_rd",   16'h0088);
        expect_out(SEL_PEND, "dir_sw_pend", 16'h0000);
        step();
        // First accepted difference after the switch raises a fall irq
        bus.rise_en = 16'h0000;
        bus.fall_en = 16'h0080;
        bus.pad_in  = 16'h0008;
        for (int c = 1; c <= 6; c++) begin
            expect_out(SEL_PEND, "dir_sw_fall", (c == 6) ? 16'h0080 : 16'h0000);
            step();
        end
        bus.irq_ack = 16'h0080;
        bus.fall_en = 16'h0000;
        expect_out(SEL_PEND, "dir_sw_ack", 16'h0000);
        step();
        bus.irq_ack = 16'h0000;

        // Reset mid-debounce forces full re-qualification
        bus.pad_in = 16'h0000;
        for (int c = 0; c < 8; c++) step();
        expect_out(SEL_RD, "settle_rd", 16'h0000);
        step();
        bus.pad_in = 16'h0001;
        for (int c = 1; c <= 3; c++) begin
            expect_out(SEL_RD, "pre_rst_rd", 16'h0000);
            step();
        end
        RST = 1'b1;
        expect_out(SEL_RD,   "mid_rst_rd",   16'h0000);
        expect_out(SEL_PEND, "mid_rst_pend", 16'h0000);
        step();
        RST = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            expect_out(SEL_RD, "requal_rd", (c == 6) ? 16'h0001 : 16'h0000);
            step();
        end

        // Random drive / direction patterns with a settled input of 0x0001
        for (int c = 0; c < 20; c++) begin
            r_out = W'($urandom_range(0, 16'hFFFF));
            r_dir = W'($urandom_range(0, 16'hFFFF));
            bus.out_val = r_out;
            bus.dir_val = r_dir;
            expect_out(SEL_PAD_OUT, "rnd_out", r_out);
            expect_out(SEL_PAD_OE,  "rnd_oe",  r_dir);
            expect_out(SEL_RD,      "rnd_rd",  (r_dir & r_out) | (~r_dir & 16'h0001));
            expect_out(SEL_PEND,    "rnd_pend", 16'h0000);
            step();
        end

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
